regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writers: the WB pipeline stage and the multi-cycle multiply/divide unit (MDU).
- The WB stage has absolute priority and is never delayed. MDU results are bypassed straight to the port when it is free, otherwise held in a small ordered queue.
- Tracks queued destinations so ID can stall on pending writes. Raises a stall request when the MDU has waited too long.
- Sits between WB/MDU and the register file write inputs (RegWrite, write_register, write_data, load_mode).

Parameters:
- DEPTH, 4, number of MDU queue entries (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive blocked cycles of a valid queue head before stall_req asserts.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  WB stage has a register write this cycle.
- wb_reg  input  5  WB destination register.
- wb_data  input  32  WB write data.
- wb_load_mode  input  2  WB load mode, passed through unchanged.
- mdu_valid  input  1  MDU result offered.
- mdu_reg  input  5  MDU destination register.
- mdu_data  input  32  MDU result.
- mdu_ready  output  1  arbiter can accept an MDU result this cycle.
- id_rs  input  5  ID-stage source register 1, for the hazard query.
- id_rt  input  5  ID-stage source register 2, for the hazard query.
- hazard  output  1  id_rs or id_rt matches a queued MDU destination.
- stall_req  output  1  request to the pipeline to bubble WB so the MDU queue can drain.
- RegWrite  output  1  register file write enable.
- write_register  output  5  register file write address.
- write_data  output  32  register file write data.
- load_mode  output  2  register file load mode.
- grant_mdu  output  1  1 when the current port write comes from the MDU path.

Behaviour:
- Reset: queue empty, all entry valid bits 0, starvation count 0, stall_req 0. Port outputs are combinational and follow the grant rules below from that cycle.
- Write-port grant, combinational, zero latency; evaluated in this order:
  1. wb_valid=1 and wb_reg≠0: RegWrite=1, port carries wb_reg, wb_data and wb_load_mode, grant_mdu=0.
  2. wb_valid=0 and the queue head is valid: head is written, load_mode=00, grant_mdu=1, head popped at the edge.
  3. wb_valid=0, queue empty, mdu_valid=1, mdu_reg≠0: bypass; MDU data written directly, grant_mdu=1, nothing enqueued.
  4. Otherwise: RegWrite=0; write_register, write_data and load_mode are 0.
- Writes to register 0 from either source: accepted (handshake completes), never written, never enqueued.
- MDU handshake:
  - mdu_ready = !full.
  - A transfer occurs when mdu_valid & mdu_ready.
  - Transferred, not bypassed, mdu_reg≠0: push to the queue tail with valid=1.
  - Full: mdu_ready=0, even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full: allowed; occupancy unchanged.
- Ordering and WAW handling:
  - The queue drains strictly in FIFO order; bypass happens only when the queue is empty.
  - When WB writes register R≠0, every queued entry with destination R has its valid bit cleared that cycle (the younger WB result wins).
  - The kill and a same-cycle push of R are not mutually exclusive: the new entry is kept.
  - An invalid (killed) head is popped silently at the next edge regardless of wb_valid, with no port write. Occupancy counts invalid entries until they are popped.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; an occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- hazard: combinational. It is 1 when any valid queued entry's destination equals id_rs or id_rt, and that register is nonzero. Bypassed and killed entries never raise it.
- Starvation:
  - The counter increments each cycle the head is valid and wb_valid=1, saturating at STARVE_LIMIT.
  - It clears on a head pop, or when the queue is empty.
  - stall_req is registered: set at the edge where the count becomes STARVE_LIMIT, cleared at the edge where the head pops or the queue empties.
  - While stall_req=1, the pipeline drives wb_valid=0; the arbiter does not depend on it for correctness.
- Reset mid-operation: queued entries are discarded without being written; mdu_ready=1 in the cycle after reset deasserts.

Test Plan:
- Bypass: queue empty, wb_valid=0, MDU offers r5=0x1234 → same cycle RegWrite=1, write_register=5, write_data=0x1234, grant_mdu=1; queue stays empty.
- Priority and drain: wb_valid=1 writing r3 while MDU offers r7 and r8 on two successive cycles → WB writes r3 each cycle, both MDU results queued, hazard=1 for id_rs=7. After wb_valid drops, r7 then r8 are written on consecutive cycles, then hazard=0.
- Full: DEPTH=4, wb_valid held at 1, four MDU transfers → mdu_ready=0 on the fifth offer. One idle WB cycle pops the head, and mdu_ready=1 on the following cycle.
- WAW kill: queue holds r9=0xAAAA; WB writes r9=0xBBBB → queued entry invalidated, hazard for r9 drops immediately, r9 is never rewritten with 0xAAAA.
- Starvation: one queued entry, wb_valid=1 for 8 cycles → stall_req rises after the 8th blocked cycle. Set wb_valid=0 → entry written, stall_req=0 at the next edge, counter reads 0.
- Zero register and reset: MDU offers r0 → handshake completes, RegWrite=0, no enqueue. Assert reset with 3 entries queued → empty queue, stall_req=0, no writes after reset releases.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the WB, MDU, hazard-query and register-file write-port signals
// around regfile_write_arbiter.
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  wb_load_mode;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        hazard;
  logic        stall_req;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [1:0]  load_mode;
  logic        grant_mdu;

  modport master (
    output wb_valid, wb_reg, wb_data, wb_load_mode,
    output mdu_valid, mdu_reg, mdu_data, id_rs, id_rt,
    input  mdu_ready, hazard, stall_req,
    input  RegWrite, write_register, write_data, load_mode, grant_mdu
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, wb_load_mode,
    input  mdu_valid, mdu_reg, mdu_data, id_rs, id_rt,
    output mdu_ready, hazard, stall_req,
    output RegWrite, write_register, write_data, load_mode, grant_mdu
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB has absolute priority, MDU results are
// bypassed when the port is idle or else queued in order, with WAW kill.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef logic [AW-1:0] ptr_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       reg_q  [DEPTH];
  logic [4:0]       reg_d  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  ptr_t             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic             stall_q, stall_d;

  logic empty, full, head_valid, wb_write, bypass, transfer, push, pop;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    head_valid = !empty && valid_q[rd_ptr_q];
    wb_write   = bus.wb_valid && (bus.wb_reg != 5'd0);
    transfer   = bus.mdu_valid && !full;
    bypass     = !bus.wb_valid && empty && bus.mdu_valid && (bus.mdu_reg != 5'd0);
    push       = transfer && !bypass && (bus.mdu_reg != 5'd0);
    // A killed head leaves silently even while WB owns the port.
    pop        = !empty && (!valid_q[rd_ptr_q] || !bus.wb_valid);
  end

  always_comb begin
    valid_d  = valid_q;
    reg_d    = reg_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + ptr_t'(1);
    end
    if (wb_write) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (reg_q[i] == bus.wb_reg) valid_d[i] = 1'b0;
      end
    end
    // Push after the kill so a same-cycle entry for the WB register survives.
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      reg_d[wr_ptr_q]   = bus.mdu_reg;
      data_d[wr_ptr_q]  = bus.mdu_data;
      wr_ptr_d          = wr_ptr_q + ptr_t'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    stall_d      = stall_q;
    if (pop || empty) begin
      starve_cnt_d = '0;
      stall_d      = 1'b0;
    end else begin
      if (head_valid && bus.wb_valid && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
      if (starve_cnt_d == SW'(STARVE_LIMIT)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

  // Payload needs no reset; it is only ever observed behind a valid bit.
  always_ff @(posedge clk) begin
    reg_q  <= reg_d;
    data_q <= data_d;
  end

  always_comb begin
    bus.hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (((reg_q[i] == bus.id_rs) && (bus.id_rs != 5'd0)) ||
                         ((reg_q[i] == bus.id_rt) && (bus.id_rt != 5'd0)))) begin
        bus.hazard = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mdu_ready      = !full;
    bus.stall_req      = stall_q;
    bus.RegWrite       = 1'b0;
    bus.write_register = 5'd0;
    bus.write_data     = 32'd0;
    bus.load_mode      = 2'd0;
    bus.grant_mdu      = 1'b0;
    if (wb_write) begin
      bus.RegWrite       = 1'b1;
      bus.write_register = bus.wb_reg;
      bus.write_data     = bus.wb_data;
      bus.load_mode      = bus.wb_load_mode;
    end else if (!bus.wb_valid && head_valid) begin
      bus.RegWrite       = 1'b1;
      bus.write_register = reg_q[rd_ptr_q];
      bus.write_data     = data_q[rd_ptr_q];
      bus.grant_mdu      = 1'b1;
    end else if (bypass) begin
      bus.RegWrite       = 1'b1;
      bus.write_register = bus.mdu_reg;
      bus.write_data     = bus.mdu_data;
      bus.grant_mdu      = 1'b1;
    end
  end
endmodule
